// File: rtl/regbank_ctx_pkg.sv
// Shared types and defaults for the context-switching register bank.
package regbank_ctx_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/regbank_ctx_seq.sv
// Save/restore sequencer: walks idx across the bank one entry per clock.
module ctx_seq
  import regbank_ctx_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          save,
  input  logic          restore,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic          save_stb_c,
  output logic          restore_stb_c
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  ctx_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Requests are only looked at in IDLE; save wins over restore.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (save) begin
          w_state_nxt = ST_SAVE;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else if (restore) begin
          w_state_nxt = ST_RESTORE;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign idx           = r_idx;
  assign save_stb_c    = (r_state == ST_SAVE);
  assign restore_stb_c = (r_state == ST_RESTORE);

endmodule

// File: rtl/regbank_ctx.sv
// General-purpose register bank with ALU operand taps and a shadow bank
// for one-register-per-clock context save/restore.
module regbank_ctx
  import regbank_ctx_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  input  logic          oe,
  input  logic [AW-1:0] oaddr,
  output logic [DW-1:0] odata,
  output logic [DW-1:0] rega,
  output logic [DW-1:0] regb,
  input  logic          save,
  input  logic          restore,
  output logic          busy,
  output logic          done
);

  logic [DW-1:0] r_main   [DEPTH];
  logic [DW-1:0] r_shadow [DEPTH];

  logic          w_busy;
  logic          w_done;
  logic [AW-1:0] w_idx;
  logic          w_save_stb;
  logic          w_restore_stb;

  ctx_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .save          (save),
    .restore       (restore),
    .busy          (w_busy),
    .done          (w_done),
    .idx           (w_idx),
    .save_stb_c    (w_save_stb),
    .restore_stb_c (w_restore_stb)
  );

  // Host writes are dropped (not queued) while the sequencer owns the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '{default: '0};
    end else if (w_restore_stb) begin
      r_main[w_idx] <= r_shadow[w_idx];
    end else if (we && !w_busy) begin
      r_main[iaddr] <= idata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '{default: '0};
    end else if (w_save_stb) begin
      r_shadow[w_idx] <= r_main[w_idx];
    end
  end

  assign odata = oe ? r_main[oaddr] : {DW{1'bz}};
  assign rega  = r_main[0];
  assign regb  = r_main[1];
  assign busy  = w_busy;
  assign done  = w_done;

endmodule

// File: tb/tb_regbank_ctx.sv
// Self-checking bench for regbank_ctx: directed scenarios plus random traffic
// compared against a behavioural model of the bank and its context copies.
module tb_regbank_ctx;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          oe;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] odata;
  logic [DW-1:0] rega;
  logic [DW-1:0] regb;
  logic          save;
  logic          restore;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  regbank_ctx #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .iaddr   (iaddr),
    .idata   (idata),
    .oe      (oe),
    .oaddr   (oaddr),
    .odata   (odata),
    .rega    (rega),
    .regb    (regb),
    .save    (save),
    .restore (restore),
    .busy    (busy),
    .done    (done)
  );

  // Model: two register images plus an in-flight copy job (kind, next entry).
  logic [DW-1:0] m_main [DEPTH];
  logic [DW-1:0] m_shad [DEPTH];
  int            m_job;      // 0 none, 1 save, 2 restore
  int            m_next;
  logic          m_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] zz;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_main[i] = '0;
      m_shad[i] = '0;
    end
    m_job  = 0;
    m_next = 0;
    m_done = 1'b0;
  endtask

  // One clock edge of the model, using the inputs the bench is holding.
  task automatic model_edge();
    m_done = 1'b0;
    if (m_job != 0) begin
      if (m_job == 1) m_shad[m_next] = m_main[m_next];
      else            m_main[m_next] = m_shad[m_next];
      m_next++;
      if (m_next == DEPTH) begin
        m_job  = 0;
        m_done = 1'b1;
      end
    end else begin
      if (we) m_main[iaddr] = idata;
      if (save)         begin m_job = 1; m_next = 0; end
      else if (restore) begin m_job = 2; m_next = 0; end
    end
  endtask

  task automatic check_outputs();
    oe    = 1'b1;
    oaddr = AW'($urandom_range(0, DEPTH - 1));
    #1;
    chk("odata", odata, m_main[oaddr]);
    chk("rega", rega, m_main[0]);
    chk("regb", regb, m_main[1]);
    chk("busy", DW'(busy), DW'(m_job != 0));
    chk("done", DW'(done), DW'(m_done));
  endtask

  task automatic peek(input string tag, input int a, input logic [DW-1:0] exp);
    oe    = 1'b1;
    oaddr = AW'(a);
    #1;
    chk(tag, odata, exp);
  endtask

  // Drive one cycle of inputs, step the model at the edge, check at negedge.
  task automatic cycle(input logic w, input int a, input logic [DW-1:0] d,
                       input logic s, input logic r);
    we = w; iaddr = AW'(a); idata = d; save = s; restore = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    we = 1'b0; save = 1'b0; restore = 1'b0;
    check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * DEPTH && busy; i++) idle_cycle();
    chk("idle_timeout", DW'(busy), '0);
  endtask

  // Asynchronous reset asserted and released inside the low clock phase.
  task automatic reset_mid();
    rst = 1'b1;
    #1;
    m_reset();
    oe = 1'b1;
    #1;
    chk("rst_odata", odata, '0);
    chk("rst_rega", rega, '0);
    chk("rst_regb", regb, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    oe = 1'b0;
    #1;
    chk("rst_odata_z", odata, zz);
    rst = 1'b0;
    oe  = 1'b1;
  endtask

  initial begin
    int bc;
    int dc;
    zz = 'z;
    rst = 1'b1; we = 0; iaddr = '0; idata = '0; oe = 1'b1; oaddr = '0;
    save = 0; restore = 0;
    m_reset();
    #2;
    chk("init_odata", odata, '0);
    chk("init_rega", rega, '0);
    chk("init_busy", DW'(busy), '0);
    oe = 1'b0;
    #1;
    chk("init_odata_z", odata, zz);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Basic write/read
    cycle(1, 3, 8'hA5, 0, 0);
    cycle(1, 0, 8'h11, 0, 0);
    cycle(1, 1, 8'h22, 0, 0);
    peek("wr_r3", 3, 8'hA5);
    chk("wr_rega", rega, 8'h11);
    chk("wr_regb", regb, 8'h22);

    reset_mid();
    idle_cycle();

    // Save with ignored write and restore pulse mid-copy
    for (int i = 0; i < DEPTH; i++) cycle(1, i, DW'(8'h10 + i), 0, 0);
    cycle(0, 0, '0, 1, 0);
    bc = busy ? 1 : 0;
    dc = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 1) cycle(1, 2, 8'h55, 0, 0);
      else if (j == 3) cycle(0, 0, '0, 0, 1);
      else idle_cycle();
      if (busy) bc++;
      if (done) dc++;
    end
    chk("save_busy_len", DW'(bc), DW'(DEPTH));
    chk("save_done_cnt", DW'(dc), 8'd1);
    peek("busy_wr_ignored", 2, 8'h12);

    // Overwrite and restore
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 8'hFF, 0, 0);
    cycle(0, 0, '0, 0, 1);
    idle_cycle();
    chk("rest_rega_first", rega, 8'h10);
    chk("rest_regb_pending", regb, 8'hFF);
    wait_idle();
    for (int i = 0; i < DEPTH; i++) peek("restored", i, DW'(8'h10 + i));

    // Write together with save, then verify through restore
    cycle(1, 5, 8'h3C, 1, 0);
    wait_idle();
    idle_cycle();
    cycle(1, 5, 8'h00, 0, 0);
    cycle(0, 0, '0, 0, 1);
    wait_idle();
    peek("wr_save_r5", 5, 8'h3C);

    // Save and restore together: save wins
    cycle(1, 0, 8'hAB, 0, 0);
    cycle(0, 0, '0, 1, 1);
    wait_idle();
    cycle(1, 0, 8'h01, 0, 0);
    cycle(0, 0, '0, 0, 1);
    wait_idle();
    chk("save_prio_r0", rega, 8'hAB);

    // Reset in the middle of a restore
    cycle(0, 0, '0, 0, 1);
    for (int j = 0; j < 4; j++) idle_cycle();
    reset_mid();
    idle_cycle();
    for (int i = 0; i < DEPTH; i++) cycle(1, i, DW'($urandom), 0, 0);
    cycle(0, 0, '0, 0, 1);
    wait_idle();
    for (int i = 0; i < DEPTH; i++) peek("rst_shadow_clr", i, '0);

    // Random traffic
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom), int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_ctx.md
# regbank_ctx

Parametrised general-purpose register bank with one write port, one tri-state read port and direct taps of registers 0 and 1 for the ALU operands. It adds a shadow bank for context save/restore, driven by an internal sequencer that copies one register per clock. It sits between the datapath bus and the ALU, and the control unit drives save/restore around interrupt entry and exit.

## Interface
- DW, 8, data width in bits
- DEPTH, 8, number of registers (power of two, ≥2)
- AW, $clog2(DEPTH), address width (derived)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable for main bank
- iaddr  in  AW  write address
- idata  in  DW  write data
- oe  in  1  read output enable
- oaddr  in  AW  read address
- odata  out  DW  main[oaddr] when oe=1, high-Z otherwise
- rega  out  DW  main[0], always driven
- regb  out  DW  main[1], always driven
- save  in  1  request copy main→shadow (sampled in IDLE only)
- restore  in  1  request copy shadow→main (sampled in IDLE only)
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse when a save/restore completes

## Operation
- States are IDLE, SAVE and RESTORE. idx is an AW-bit copy counter.
- IDLE:
  - we=1 writes idata to main[iaddr] at the edge.
  - If save=1: go to SAVE with idx=0.
  - Else if restore=1: go to RESTORE with idx=0.
  - save has priority over restore when both are asserted.
- SAVE: each edge performs shadow[idx]←main[idx] and idx←idx+1. At idx=DEPTH-1, go to IDLE and set done.
- RESTORE: each edge performs main[idx]←shadow[idx] and idx←idx+1. At idx=DEPTH-1, go to IDLE and set done.
- While busy:
  - we is ignored, with no write and no queuing.
  - save and restore are ignored.
  - Reads (odata, rega, regb) stay live and show the current main contents, including entries already restored.
- In IDLE, a write and save in the same cycle: the write commits at that edge, and the save copies the new value.
- In IDLE, a write and restore in the same cycle: the write commits, and is overwritten when its index is restored.
- Shadow is never directly readable or writable.
- Reads are combinational from the main bank. There is no write-through: a write becomes visible on the outputs after the edge.
- Reset (async, any state, including mid-copy):
  - main and shadow are all zero.
  - State is IDLE, idx=0, busy=0, done=0.
  - rega=regb=0; odata is 0 if oe=1, otherwise Z.

## Timing
- Write latency: 1 edge.
- Read latency: 0. odata, rega and regb are combinational.
- A save/restore accepted at edge k copies entry i at edge k+1+i. The sequencer returns to IDLE at edge k+DEPTH.
- busy is 1 after edge k through edge k+DEPTH, i.e. DEPTH cycles.
- done is 1 for exactly one cycle, after edge k+DEPTH.
- A new request can be accepted in the cycle done is high, because the sequencer is already in IDLE. Back-to-back operations take DEPTH+1 edges each.
- busy and done are registered outputs with no combinational path from inputs.

## Structure
- Shared package contains the state enum (IDLE/SAVE/RESTORE, 2 bits) and default DW and DEPTH constants.
- One natural sub-module: ctx_seq, the state machine plus idx counter. It outputs busy, done, idx and copy-direction strobes.
- The storage arrays and port muxing stay in the top-level module.

## Test plan
- **Reset / tri-state:** assert rst mid-cycle with oe=1 → odata=0, rega=regb=0, busy=0. With oe=0 → odata=Z.
- **Write/read:** write 0xA5 to r3, 0x11 to r0, 0x22 to r1. Then oaddr=3, oe=1 → odata=0xA5, rega=0x11, regb=0x22.
- **Save/restore round trip:**
  - Load r0..r7=0x10..0x17 and pulse save. Expect busy for 8 cycles, then done for 1 cycle.
  - Overwrite all registers with 0xFF and pulse restore. Expect r0..r7=0x10..0x17.
  - During the restore, rega must become 0x10 one edge after acceptance while regb is still 0xFF.
- **Ignored inputs while busy:**
  - During SAVE, assert we to r2=0x55 → r2 is unchanged.
  - Pulse restore mid-save → ignored, and busy ends exactly 8 cycles after acceptance.
- **Simultaneous events:**
  - In IDLE, we r5=0x3C together with save → shadow[5]=0x3C, verified by a later restore.
  - save and restore together → SAVE executes.
- **Reset mid-restore:** assert rst at idx=4 → all registers=0, busy=0, no done pulse. A following restore yields all zeros because shadow was cleared.
